// File: rtl/gate_edge_if.sv
// Signal bundle between the gate stage / controller and gate_edge_counter.
// The master drives the gate outputs and clear; the slave returns count, pulse, flag and FSM state.
interface gate_edge_if #(
  parameter int CNT_W = 8
);
  logic             c_in;
  logic             d_in;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             rise_pulse;
  logic             thresh_hit;
  logic [1:0]       state;

  modport master (
    output c_in, d_in, clr,
    input  count, rise_pulse, thresh_hit, state
  );

  modport slave (
    input  c_in, d_in, clr,
    output count, rise_pulse, thresh_hit, state
  );
endinterface

// File: rtl/gate_edge_counter.sv
// Synchronises and debounces the gate-stage c/d outputs, counts clean rising edges of c while d is high.
// Optional feature: define GATE_CNT_WRAP_EN to make count wrap instead of saturating.
module gate_edge_counter #(
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 4,
  parameter int THRESH     = 10
) (
  input  logic        clk,
  input  logic        rst,
  gate_edge_if.slave  bus
);

  localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  logic             c_meta_q, c_s_q;
  logic             d_meta_q, d_s_q;
  state_t           state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0] deb_inc;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             thresh_q, thresh_d;
  logic             inc;

  // Two-flop synchronisers; both inputs are asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_meta_q <= 1'b0;
      c_s_q    <= 1'b0;
      d_meta_q <= 1'b0;
      d_s_q    <= 1'b0;
    end else begin
      c_meta_q <= bus.c_in;
      c_s_q    <= c_meta_q;
      d_meta_q <= bus.d_in;
      d_s_q    <= d_meta_q;
    end
  end

  assign deb_inc = deb_cnt_q + DEB_ONE;

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    pulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_s_q) begin
          if (DEB_CYCLES == 1) begin
            state_d = HIGH;
            pulse_d = 1'b1;
          end else begin
            state_d   = RISE_CHK;
            deb_cnt_d = DEB_ONE;
          end
        end
      end
      RISE_CHK: begin
        if (!c_s_q) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d   = HIGH;
          pulse_d   = 1'b1;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      HIGH: begin
        if (!c_s_q) begin
          if (DEB_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d   = FALL_CHK;
            deb_cnt_d = DEB_ONE;
          end
        end
      end
      FALL_CHK: begin
        if (c_s_q) begin
          state_d   = HIGH;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // The count enable is sampled on the same edge that raises rise_pulse.
  assign inc = pulse_d & d_s_q;

  always_comb begin
    count_d  = count_q;
    thresh_d = thresh_q;
    if (bus.clr) begin
      count_d  = '0;
      thresh_d = 1'b0;
    end else if (inc) begin
`ifdef GATE_CNT_WRAP_EN
      count_d = count_q + 1'b1;
`else
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
`endif
      if (count_d == THRESH_V) begin
        thresh_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
      thresh_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
      thresh_q  <= thresh_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.rise_pulse = pulse_q;
  assign bus.thresh_hit = thresh_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_gate_edge_counter.sv
// Bench for gate_edge_counter: directed scenarios with literal expectations plus random
// stimulus, all checked every cycle against a level/run-length model of the debouncer.
module tb_gate_edge_counter;
  localparam int CNT_W  = 8;
  localparam int DEB    = 4;
  localparam int THRESH = 10;
  localparam int MAXV   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gate_edge_if #(.CNT_W(CNT_W)) bus ();

  gate_edge_counter #(
    .CNT_W(CNT_W),
    .DEB_CYCLES(DEB),
    .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: c_s is c_in seen two edges late; the accepted level flips once the
  // synchronised value has disagreed with it for DEB consecutive samples.
  bit c_hist[$];
  bit d_hist[$];
  bit m_cs, m_ds;
  int m_level = 0;
  int m_run   = 0;
  int m_cnt   = 0;
  bit m_pulse = 1'b0;
  bit m_thr   = 1'b0;

  function automatic int model_state();
    if (m_level == 0) return (m_run > 0) ? 1 : 0;
    return (m_run > 0) ? 3 : 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_hist  = '{1'b0, 1'b0};
      d_hist  = '{1'b0, 1'b0};
      m_level = 0;
      m_run   = 0;
      m_cnt   = 0;
      m_pulse = 1'b0;
      m_thr   = 1'b0;
    end else begin
      m_cs = c_hist.pop_front();
      m_ds = d_hist.pop_front();
      c_hist.push_back(bus.c_in);
      d_hist.push_back(bus.d_in);
      m_pulse = 1'b0;
      if (int'(m_cs) != m_level) begin
        m_run++;
        if (m_run >= DEB) begin
          m_level = int'(m_cs);
          m_run   = 0;
          m_pulse = m_cs;
        end
      end else begin
        m_run = 0;
      end
      if (bus.clr) begin
        m_cnt = 0;
        m_thr = 1'b0;
      end else if (m_pulse && m_ds) begin
`ifdef GATE_CNT_WRAP_EN
        m_cnt = (m_cnt + 1) % (MAXV + 1);
`else
        m_cnt = (m_cnt < MAXV) ? m_cnt + 1 : MAXV;
`endif
        if (m_cnt == THRESH) m_thr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_count", bus.count, m_cnt);
    check("cmp_rise_pulse", bus.rise_pulse, m_pulse);
    check("cmp_thresh_hit", bus.thresh_hit, m_thr);
    check("cmp_state", bus.state, model_state());
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic edge_pulse(input int hi, input int lo, output int pulses);
    pulses = 0;
    bus.c_in = 1'b1;
    repeat (hi) begin
      tick();
      if (bus.rise_pulse) pulses++;
    end
    bus.c_in = 1'b0;
    repeat (lo) begin
      tick();
      if (bus.rise_pulse) pulses++;
    end
  endtask

  int first, np, p, total;
  bit saw_rise_chk;

  initial begin
    bus.c_in = 1'b0;
    bus.d_in = 1'b0;
    bus.clr  = 1'b0;
    repeat (3) tick();
    check("reset_count", bus.count, 0);
    check("reset_state", bus.state, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean edge: pulse visible after the sixth edge, one cycle wide.
    bus.d_in = 1'b1;
    bus.c_in = 1'b1;
    first = 0;
    np = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.rise_pulse) begin
        np++;
        if (first == 0) first = i;
      end
    end
    check("clean_latency", first, 6);
    check("clean_width", np, 1);
    check("clean_count", bus.count, 1);
    check("clean_state_high", bus.state, 2);
    bus.c_in = 1'b0;
    repeat (8) tick();
    check("clean_state_idle", bus.state, 0);

    // Glitch of 3 cycles: enters RISE_CHK, falls back, no pulse.
    saw_rise_chk = 1'b0;
    np = 0;
    bus.c_in = 1'b1;
    repeat (3) begin
      tick();
      if (bus.state == 2'd1) saw_rise_chk = 1'b1;
      if (bus.rise_pulse) np++;
    end
    bus.c_in = 1'b0;
    repeat (6) begin
      tick();
      if (bus.state == 2'd1) saw_rise_chk = 1'b1;
      if (bus.rise_pulse) np++;
    end
    check("glitch_saw_rise_chk", saw_rise_chk, 1);
    check("glitch_no_pulse", np, 0);
    check("glitch_count", bus.count, 1);
    check("glitch_state", bus.state, 0);

    // Enable gating and threshold.
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_count", bus.count, 0);
    bus.d_in = 1'b0;
    repeat (3) tick();
    edge_pulse(8, 8, p);
    check("disabled_pulse", p, 1);
    check("disabled_count", bus.count, 0);
    bus.d_in = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 9; i++) edge_pulse(8, 8, p);
    check("thresh_count9", bus.count, 9);
    check("thresh_low_at9", bus.thresh_hit, 0);
    edge_pulse(8, 8, p);
    check("thresh_count10", bus.count, 10);
    check("thresh_hit_at10", bus.thresh_hit, 1);

    // clr on the same edge as an accepted rise.
    bus.c_in = 1'b1;
    repeat (5) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_coinc_pulse", bus.rise_pulse, 1);
    check("clr_coinc_count", bus.count, 0);
    check("clr_coinc_thresh", bus.thresh_hit, 0);
    bus.c_in = 1'b0;
    repeat (8) tick();

    // Asynchronous reset mid-debounce.
    edge_pulse(8, 8, p);
    check("pre_reset_count", bus.count, 1);
    bus.c_in = 1'b1;
    repeat (3) tick();
    #5 rst = 1'b1;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_pulse", bus.rise_pulse, 0);
    check("async_rst_thresh", bus.thresh_hit, 0);
    check("async_rst_state", bus.state, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.c_in = 1'b0;
    repeat (4) tick();

    // Overflow: 256 accepted edges.
    bus.d_in = 1'b1;
    total = 0;
    for (int i = 0; i < 256; i++) begin
      edge_pulse(8, 8, p);
      total += p;
    end
    check("ovf_pulses", total, 256);
`ifdef GATE_CNT_WRAP_EN
    check("ovf_count", bus.count, 0);
`else
    check("ovf_count", bus.count, MAXV);
`endif
    check("ovf_thresh", bus.thresh_hit, 1);

    // Random stimulus, checked every cycle by the compare process.
    for (int s = 0; s < 400; s++) begin
      bus.c_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.d_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 10)) begin
        bus.clr = ($urandom_range(0, 63) == 0);
        tick();
      end
      bus.clr = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
